// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus start/done sequencer sitting in front of the TinyALU.
// Optional hung-operation abort is compiled in with `define ALU_TIMEOUT_EN.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [7:0]              cmd_a,
    input  logic [7:0]              cmd_b,
    output logic                    alu_start,
    output logic [2:0]              alu_op,
    output logic [7:0]              alu_a,
    output logic [7:0]              alu_b,
    output logic                    alu_rst,
    input  logic                    alu_done,
    input  logic [15:0]             alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_result,
    output logic [2:0]              rsp_op,
    output logic                    rsp_err,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_UND = 3'b110;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_NOP,
        S_RST,
        S_RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             push;
    logic             pop;

    logic [2:0]       op_d;
    logic [7:0]       a_d;
    logic [7:0]       b_d;
    logic [15:0]      res_d;
    logic [2:0]       rop_d;
    logic             err_d;

    assign push = cmd_valid && cmd_ready;
    assign pop  = (state_q == S_IDLE) && (fifo_count != '0);
    assign head = mem[rd_ptr];

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    always_comb begin
        count_d = fifo_count;
        case ({push, pop})
            2'b10:   count_d = fifo_count + CNT_W'(1);
            2'b01:   count_d = fifo_count - CNT_W'(1);
            default: count_d = fifo_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_ready  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_d;
            cmd_ready  <= (count_d < CNT_W'(DEPTH));
        end
    end

`ifdef ALU_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q;
    logic             tmr_expired;

    assign tmr_expired = (timer_q == TMR_W'(TIMEOUT - 1));

    // Counts edges spent in ISSUE; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (state_q != S_ISSUE) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end
`else
    // TIMEOUT only has meaning when the abort timer is compiled in.
    if (TIMEOUT == 0) begin : g_no_timer
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = alu_op;
        a_d     = alu_a;
        b_d     = alu_b;
        res_d   = rsp_result;
        rop_d   = rsp_op;
        err_d   = rsp_err;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    a_d = head.a;
                    b_d = head.b;
                    case (head.op)
                        OP_RST: begin
                            op_d    = OP_RST;
                            state_d = S_RST;
                        end
                        OP_NOP, OP_UND: begin
                            op_d    = OP_NOP;
                            state_d = S_NOP;
                        end
                        default: begin
                            op_d    = head.op;
                            state_d = S_ISSUE;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (alu_done) begin
                    res_d   = alu_result;
                    rop_d   = alu_op;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef ALU_TIMEOUT_EN
                else if (tmr_expired) begin
                    res_d   = 16'h0000;
                    rop_d   = alu_op;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
`endif
            end
            S_NOP, S_RST: begin
                state_d = S_IDLE;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered copies decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            alu_start  <= 1'b0;
            alu_rst    <= 1'b0;
            alu_op     <= 3'b000;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_op     <= 3'b000;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_start  <= (state_d == S_ISSUE) || (state_d == S_NOP);
            alu_rst    <= (state_d == S_RST);
            alu_op     <= op_d;
            alu_a      <= a_d;
            alu_b      <= b_d;
            rsp_valid  <= (state_d == S_RESP);
            rsp_result <= res_d;
            rsp_op     <= rop_d;
            rsp_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: TinyALU model, response scoreboard,
// vector table and hand sequences for latency, back-pressure, no_op/rst, timeout and reset.
module tb_alu_cmd_issuer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    typedef struct {
        logic [15:0] result;
        logic [2:0]  op;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] result;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [7:0]    cmd_a;
    logic [7:0]    cmd_b;
    logic          alu_start;
    logic [2:0]    alu_op;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic          alu_rst;
    logic          alu_done = 1'b0;
    logic [15:0]   alu_result = 16'h0000;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_result;
    logic [2:0]    rsp_op;
    logic          rsp_err;
    logic [CW-1:0] fifo_count;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_rst    (alu_rst),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'b100:  return 3;
            3'b101:  return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            3'b101:  return {b, a};
            default: return 16'h0000;
        endcase
    endfunction

    // TinyALU model: done in the lat-th cycle of start, result valid only with done.
    int alu_cyc = 0;
    bit alu_hang = 1'b0;
    always @(negedge clk) begin
        if (alu_start) alu_cyc = alu_cyc + 1;
        else           alu_cyc = 0;
        alu_done   = alu_start && !alu_hang && (alu_cyc == lat_of(alu_op));
        alu_result = alu_done ? alu_calc(alu_op, alu_a, alu_b) : 16'h0000;
    end

    // Response scoreboard: a response is consumed when valid && ready at the next edge.
    always begin
        @(negedge clk);
        #2;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got result 0x%0h op %0d with nothing expected", rsp_result, rsp_op);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_result", 32'(rsp_result), 32'(e.result));
                chk("rsp_op", 32'(rsp_op), 32'(e.op));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    bit cnt_en = 1'b0;
    int n_start = 0;
    int n_rst = 0;
    int n_rsp = 0;
    int n_both = 0;
    always @(negedge clk) begin
        if (cnt_en) begin
            if (alu_start) n_start++;
            if (alu_rst) n_rst++;
            if (rsp_valid) n_rsp++;
            if (alu_start && alu_rst) n_both++;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit want, input exp_t e);
        bit ok;
        ok = 1'b0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                if (want) sb.push_back(e);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("send_accept", 32'(ok), 1);
    endtask

    task automatic drain(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid && !alu_start && fifo_count == '0) ok = 1'b1;
        end
        chk(name, 32'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        exp_t none;
        int   n;
        bit   flag;

        none = '{16'h0000, 3'b000, 1'b0};
        vt[0] = '{3'b001, 8'h05, 8'h03, 16'h0008};
        vt[1] = '{3'b010, 8'hF0, 8'h3C, 16'h0030};
        vt[2] = '{3'b011, 8'hAA, 8'h0F, 16'h00A5};
        vt[3] = '{3'b100, 8'hFF, 8'hFF, 16'hFE01};
        vt[4] = '{3'b001, 8'hFF, 8'hFF, 16'h01FE};
        vt[5] = '{3'b100, 8'h12, 8'h34, 16'h03A8};
        vt[6] = '{3'b101, 8'h07, 8'h02, 16'h0207};
        vt[7] = '{3'b010, 8'hFF, 8'hFF, 16'h00FF};

        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        rsp_ready = 1'b0;

        #1 reset = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_alu_start", 32'(alu_start), 0);
        chk("rst_alu_rst", 32'(alu_rst), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single add: latency and one-cycle response.
        rsp_ready = 1'b1;
        send(3'b001, 8'h05, 8'h03, 1'b1, '{16'h0008, 3'b001, 1'b0});
        chk("add_start_t0", 32'(alu_start), 0);
        chk("add_count_t0", 32'(fifo_count), 1);
        @(negedge clk);
        chk("add_start_t1", 32'(alu_start), 1);
        chk("add_op_t1", 32'(alu_op), 1);
        chk("add_a_t1", 32'(alu_a), 'h05);
        chk("add_b_t1", 32'(alu_b), 'h03);
        chk("add_count_t1", 32'(fifo_count), 0);
        chk("add_rsp_t1", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("add_rsp_t2", 32'(rsp_valid), 1);
        chk("add_start_t2", 32'(alu_start), 0);
        @(negedge clk);
        chk("add_rsp_t3", 32'(rsp_valid), 0);
        drain("add_drain", 20);

        // Multi-cycle mul: start held three cycles with stable operands.
        send(3'b100, 8'hFF, 8'hFF, 1'b1, '{16'hFE01, 3'b100, 1'b0});
        n = 0;
        flag = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (alu_start) begin
                n++;
                if (alu_a !== 8'hFF || alu_b !== 8'hFF || alu_op !== 3'b100) flag = 1'b0;
            end
        end
        chk("mul_start_cycles", 32'(n), 3);
        chk("mul_operands_stable", 32'(flag), 1);
        drain("mul_drain", 20);

        // Vector table, pushed back to back.
        for (int i = 0; i < 8; i++) begin
            send(vt[i].op, vt[i].a, vt[i].b, 1'b1, '{vt[i].result, vt[i].op, 1'b0});
        end
        drain("table_drain", 200);

        // Back-pressure: five pushes fill the FIFO behind a stalled response.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(3'b001, 8'(i), 8'h10, 1'b1, '{16'(16'h0010 + i), 3'b001, 1'b0});
        end
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(cmd_ready), 0);
        cmd_op    = 3'b001;
        cmd_a     = 8'h77;
        cmd_b     = 8'h77;
        cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_count", 32'(fifo_count), 4);
            chk("full_hold_ready", 32'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        chk("full_rsp_stalled", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        drain("full_drain", 200);

        // no_op, undefined op, rst_op: two start pulses, one rst pulse, no response.
        n_start = 0;
        n_rst   = 0;
        n_rsp   = 0;
        n_both  = 0;
        cnt_en  = 1'b1;
        send(3'b000, 8'h01, 8'h02, 1'b0, none);
        send(3'b110, 8'h03, 8'h04, 1'b0, none);
        send(3'b111, 8'h05, 8'h06, 1'b0, none);
        repeat (10) @(negedge clk);
        cnt_en = 1'b0;
        chk("nop_start_pulses", 32'(n_start), 2);
        chk("rst_pulses", 32'(n_rst), 1);
        chk("nop_rst_no_rsp", 32'(n_rsp), 0);
        chk("rst_without_start", 32'(n_both), 0);
        chk("nop_rst_count", 32'(fifo_count), 0);

        // Hung xor.
        alu_hang = 1'b1;
`ifdef ALU_TIMEOUT_EN
        send(3'b011, 8'h3C, 8'h0F, 1'b1, '{16'h0000, 3'b011, 1'b1});
        n = 0;
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                flag = 1'b1;
                break;
            end
            if (alu_start) n++;
        end
        chk("timeout_start_cycles", 32'(n), 15);
        chk("timeout_rsp_seen", 32'(flag), 1);
        alu_hang = 1'b0;
        drain("timeout_drain", 20);
`else
        send(3'b011, 8'h3C, 8'h0F, 1'b0, none);
        repeat (40) @(negedge clk);
        chk("hang_start_held", 32'(alu_start), 1);
        chk("hang_no_rsp", 32'(rsp_valid), 0);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        alu_hang = 1'b0;
        chk("hang_reset_start", 32'(alu_start), 0);
`endif

        // Reset while issuing with three commands queued.
        rsp_ready = 1'b0;
        alu_hang  = 1'b1;
        send(3'b001, 8'h01, 8'h01, 1'b1, '{16'h0002, 3'b001, 1'b0});
        send(3'b001, 8'h02, 8'h02, 1'b1, '{16'h0004, 3'b001, 1'b0});
        send(3'b001, 8'h03, 8'h03, 1'b1, '{16'h0006, 3'b001, 1'b0});
        send(3'b001, 8'h04, 8'h04, 1'b1, '{16'h0008, 3'b001, 1'b0});
        chk("pre_rst_count", 32'(fifo_count), 3);
        chk("pre_rst_start", 32'(alu_start), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_start", 32'(alu_start), 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        sb.delete();
        @(negedge clk);
        reset     = 1'b0;
        alu_hang  = 1'b0;
        rsp_ready = 1'b1;
        send(3'b001, 8'h21, 8'h12, 1'b1, '{16'h0033, 3'b001, 1'b0});
        send(3'b100, 8'h10, 8'h10, 1'b1, '{16'h0100, 3'b100, 1'b0});
        drain("post_rst_drain", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
